// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch stage.
//   fetch_state_t : fetch FSM encoding
//   PC_W/INSTR_W  : default address / instruction widths
//   RESET_PC      : PC loaded on reset
//   PC_INC        : sequential increment (byte-addressed 16-bit instructions)
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  localparam logic [PC_W-1:0] PC_INC   = 16'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} skid buffer. Catches returned fetch data when the
// IF/ID register is occupied and stalled.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load_i             : capture instr_i/pc_i, mark full
//   unload_i, flush_i  : mark empty (unload = consumed, flush = discarded)
//   instr_i, pc_i      : payload to capture
//   full_o             : entry holds valid data
//   instr_o, pc_o      : stored payload
module fetch_skid_buf #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  always_comb begin
    full_d = full_q;
    if (unload_i || flush_i) full_d = 1'b0;
    if (load_i)              full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // Payload is only meaningful while full_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the architectural PC, issues single-outstanding 16-bit
// fetches, applies branch redirects and presents {instr, pc, pc+PC_INC} to
// IF/ID with valid/stall handshaking.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc   : resolved branch/jump target (1-cycle pulse)
//   stall                         : IF/ID not accepting
//   halt                          : stop fetching (level)
//   imem_req/addr/gnt/rvalid/rdata: instruction memory port
//   if_valid/instr/pc/pc_next     : registered IF/ID payload
//   halted                        : fetch stopped, sticky until reset
module fetch_pc_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [PC_W-1:0] PC_INC   = cpu_pkg::PC_INC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_next,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               drop_q, drop_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    if_pc_next_q, if_pc_next_d;

  logic               skid_load, skid_unload, skid_flush, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic               gnt_ok, slot_free, redir;
  logic [PC_W-1:0]    redir_pc, ret_pc;

  assign imem_req  = (state_q == FETCH) && !halt;
  assign imem_addr = pc_q;
  assign gnt_ok    = imem_req && imem_gnt;
  assign slot_free = !if_valid_q || !stall;
  assign redir     = redirect_valid && (state_q inside {FETCH, WAIT, HOLD});
  assign redir_pc  = {redirect_pc[PC_W-1:1], 1'b0};
  // pc was advanced at grant, so returned data belongs to the previous address.
  // Redirects never reach this path: they either drop or discard the data.
  assign ret_pc    = pc_q - PC_INC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pc_next_d = if_pc_next_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;

    // Payload consumed this cycle and nothing new arrives: slot empties.
    if (!stall) if_valid_d = 1'b0;

    if (redir) begin
      pc_d       = redir_pc;
      if_valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          // A fetch granted alongside the redirect is for the stale pc.
          if (gnt_ok) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end else if (halt) begin
            state_d = HALT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = halt ? HALT : FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end
        HOLD: begin
          skid_flush = 1'b1;
          state_d    = halt ? HALT : FETCH;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (gnt_ok) begin
            pc_d    = pc_q + PC_INC;
            state_d = WAIT;
          end else if (halt) begin
            state_d = HALT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = halt ? HALT : FETCH;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (slot_free) begin
              if_valid_d   = 1'b1;
              if_instr_d   = imem_rdata;
              if_pc_d      = ret_pc;
              if_pc_next_d = ret_pc + PC_INC;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && skid_full) begin
            skid_unload  = 1'b1;
            if_valid_d   = 1'b1;
            if_instr_d   = skid_instr;
            if_pc_d      = skid_pc;
            if_pc_next_d = skid_pc + PC_INC;
            state_d      = halt ? HALT : FETCH;
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc_next_q <= RESET_PC + PC_INC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc_next_q <= if_pc_next_d;
    end
  end

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .instr_i  (imem_rdata),
    .pc_i     (ret_pc),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_pc_next = if_pc_next_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;
  logic        halted;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcn;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_gnt  = 0;
  int n_done = 0;
  int lat    = 1;

  logic        gnt_en   = 1'b0;
  logic        stray    = 1'b0;
  logic        ovr_en   = 1'b0;
  logic [15:0] ovr_addr = 16'h0000;
  logic [15:0] ovr_data = 16'h0000;

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .halt           (halt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_next     (if_pc_next),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = grant count, 1 = completed access count, 2 = if_valid high
  task automatic wait_until(input int which, input int target, input string what);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick();
      case (which)
        0:       ok = (n_gnt >= target);
        1:       ok = (n_done >= target);
        default: ok = (if_valid === 1'b1);
      endcase
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_%s: condition not reached, required within 100 cycles", what);
    end
  endtask

  task automatic settle();
    wait_until(1, n_gnt, "settle");
    tick();
    tick();
  endtask

  task automatic redirect(input logic [15:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [15:0] p, input logic [15:0] pn);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.pcn   = pn;
    exp_q.push_back(e);
  endtask

  // Instruction memory: data = addr ^ 16'hC300 unless overridden; checks
  // every granted address against the expected-address queue.
  initial begin : mem_model
    logic        pend;
    logic [15:0] pend_addr;
    int          cnt;
    logic [15:0] a;
    pend        = 1'b0;
    pend_addr   = 16'h0000;
    cnt         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = (ovr_en && pend_addr == ovr_addr) ? ovr_data : (pend_addr ^ 16'hC300);
          pend        = 1'b0;
          n_done++;
        end else begin
          cnt--;
        end
      end else if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        stray       = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        if (pend) begin
          pend = 1'b0;
          n_done++;
        end
      end else if (imem_req && imem_gnt) begin
        if (addr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_fetch: got addr %h, required no request", imem_addr);
        end else begin
          a = addr_q.pop_front();
          chk("imem_addr", imem_addr, a);
        end
        pend      = 1'b1;
        pend_addr = imem_addr;
        cnt       = lat;
        n_gnt++;
      end
    end
  end

  // Monitor: every payload accepted by IF/ID is popped and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got instr %h pc %h, required no output", if_instr, if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_instr", if_instr, e.instr);
          chk("if_pc", if_pc, e.pc);
          chk("if_pc_next", if_pc_next, e.pcn);
        end
      end
    end
  end

  initial begin : main
    int g;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    stall          = 1'b0;
    halt           = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_imem_req", {15'd0, imem_req}, 16'd0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_if_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_if_instr", if_instr, 16'h0000);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_if_pc_next", if_pc_next, 16'h0002);
    chk("rst_halted", {15'd0, halted}, 16'd0);

    // Sequential fetch, 1-cycle memory
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    addr_q.push_back(16'h0004);
    push_exp(16'hC300, 16'h0000, 16'h0002);
    push_exp(16'hC302, 16'h0002, 16'h0004);
    push_exp(16'hC304, 16'h0004, 16'h0006);
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    g = n_gnt;
    wait_until(0, g + 3, "seq_grants");
    gnt_en = 1'b0;
    settle();

    // Late stall: second fetch lands in the skid buffer
    addr_q.push_back(16'h0006);
    addr_q.push_back(16'h0008);
    push_exp(16'hC306, 16'h0006, 16'h0008);
    push_exp(16'hA5A5, 16'h0008, 16'h000A);
    ovr_en   = 1'b1;
    ovr_addr = 16'h0008;
    ovr_data = 16'hA5A5;
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "skid_grant1");
    lat = 3;
    wait_until(2, 0, "skid_valid");
    stall = 1'b1;
    wait_until(0, g + 2, "skid_grant2");
    gnt_en = 1'b0;
    wait_until(1, g + 2, "skid_rvalid");
    chk("hold_imem_req", {15'd0, imem_req}, 16'd0);
    chk("hold_if_instr", if_instr, 16'hC306);
    chk("hold_if_pc", if_pc, 16'h0006);
    chk("hold_if_valid", {15'd0, if_valid}, 16'd1);
    tick();
    chk("hold_imem_req2", {15'd0, imem_req}, 16'd0);
    chk("hold_if_instr2", if_instr, 16'hC306);
    stall = 1'b0;
    lat   = 1;
    settle();
    ovr_en = 1'b0;

    // Redirect while waiting: outstanding data dropped
    redirect(16'h0010);
    addr_q.push_back(16'h0010);
    lat = 3;
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "drop_grant");
    gnt_en = 1'b0;
    lat    = 1;
    redirect(16'h0040);
    chk("redir_addr_40", imem_addr, 16'h0040);
    addr_q.push_back(16'h0040);
    push_exp(16'hC340, 16'h0040, 16'h0042);
    gnt_en = 1'b1;
    wait_until(0, g + 2, "redir_grant");
    gnt_en = 1'b0;
    settle();

    // PC wrap and redirect bit0 masking
    redirect(16'hFFFE);
    addr_q.push_back(16'hFFFE);
    addr_q.push_back(16'h0000);
    push_exp(16'h3CFE, 16'hFFFE, 16'h0000);
    push_exp(16'hC300, 16'h0000, 16'h0002);
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 2, "wrap_grants");
    gnt_en = 1'b0;
    settle();
    redirect(16'h0013);
    chk("redir_addr_12", imem_addr, 16'h0012);
    addr_q.push_back(16'h0012);
    push_exp(16'hC312, 16'h0012, 16'h0014);
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "odd_grant");
    gnt_en = 1'b0;
    settle();

    // Halt while waiting: data delivered, then halted and redirect ignored
    addr_q.push_back(16'h0014);
    push_exp(16'hC314, 16'h0014, 16'h0016);
    lat = 3;
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "halt_grant");
    gnt_en = 1'b0;
    halt   = 1'b1;
    wait_until(1, g + 1, "halt_rvalid");
    tick();
    chk("halted", {15'd0, halted}, 16'd1);
    chk("halt_imem_req", {15'd0, imem_req}, 16'd0);
    redirect(16'h0080);
    tick();
    chk("halt_addr_kept", imem_addr, 16'h0016);
    chk("halted_sticky", {15'd0, halted}, 16'd1);
    chk("halt_imem_req2", {15'd0, imem_req}, 16'd0);
    chk("halt_if_valid", {15'd0, if_valid}, 16'd0);

    // Reset from HALT, then reset mid-WAIT with a stray rvalid afterwards
    halt  = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst2_halted", {15'd0, halted}, 16'd0);
    chk("rst2_if_instr", if_instr, 16'h0000);
    chk("rst2_if_pc_next", if_pc_next, 16'h0002);
    chk("rst2_imem_addr", imem_addr, 16'h0000);
    rst_n = 1'b1;
    addr_q.push_back(16'h0000);
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "rst_grant");
    gnt_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst3_imem_req", {15'd0, imem_req}, 16'd0);
    chk("rst3_imem_addr", imem_addr, 16'h0000);
    chk("rst3_if_valid", {15'd0, if_valid}, 16'd0);
    tick();
    rst_n = 1'b1;
    stray = 1'b1;
    tick();
    tick();
    lat = 1;
    addr_q.push_back(16'h0000);
    push_exp(16'hC300, 16'h0000, 16'h0002);
    g = n_gnt;
    gnt_en = 1'b1;
    wait_until(0, g + 1, "restart_grant");
    gnt_en = 1'b0;
    settle();

    chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
    chk("addr_q_empty", 16'(addr_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, required completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
